// File: rtl/lsu_if.sv
// Bundle of the LSU's three channels: execute request, data-memory bus and
// writeback response. The LSU connects to the slave modport; the execute
// stage, memory and writeback side connect to the master modport.
interface lsu_if;
    // Execute-side request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    // Data-memory bus
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    // Writeback response
    logic        rsp_valid;
    logic        rsp_rf_we;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output rsp_valid, rsp_rf_we, rsp_rd, rsp_rdata, rsp_err, busy
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  rsp_valid, rsp_rf_we, rsp_rd, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction at a time over a req/gnt/rvalid
// bus, with lane steering for stores, extraction/extension for loads, and a
// REQ+WAIT timeout. Every output is a register.
module lsu #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrIllegal = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_we;
    logic [2:0]    op_f3;
    logic [1:0]    op_off;
    logic [4:0]    op_rd;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we) return f3[2] || (f3 == 3'b011);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(input logic we, input logic [2:0] f3,
                                            input logic [1:0] off);
        if (!we) return 4'hF;
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic we, input logic [2:0] f3,
                                               input logic [31:0] d);
        if (!we) return 32'h0;
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        b_sh = rd >> {off, 3'b000};
        h_sh = rd >> {off[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{b_sh[7]}}, b_sh[7:0]};
            3'b100:  return {24'h0, b_sh[7:0]};
            3'b001:  return {{16{h_sh[15]}}, h_sh[15:0]};
            3'b101:  return {16'h0, h_sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // Transaction FSM; all outputs are updated alongside the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            cnt            <= '0;
            op_we          <= 1'b0;
            op_f3          <= 3'b000;
            op_off         <= 2'b00;
            op_rd          <= 5'd0;
            bus.req_ready  <= 1'b1;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= 32'h0;
            bus.dmem_be    <= 4'h0;
            bus.dmem_wdata <= 32'h0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rf_we  <= 1'b0;
            bus.rsp_rd     <= 5'd0;
            bus.rsp_rdata  <= 32'h0;
            bus.rsp_err    <= ErrNone;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_we         <= bus.req_we;
                        op_f3         <= bus.req_funct3;
                        op_off        <= bus.req_addr[1:0];
                        op_rd         <= bus.req_rd;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (is_illegal(bus.req_we, bus.req_funct3) ||
                            is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                            // Illegal funct3 outranks misalignment.
                            state         <= StResp;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rf_we <= 1'b0;
                            bus.rsp_rd    <= bus.req_rd;
                            bus.rsp_rdata <= 32'h0;
                            bus.rsp_err   <= is_illegal(bus.req_we, bus.req_funct3) ?
                                             ErrIllegal : ErrAlign;
                        end else begin
                            state          <= StReq;
                            cnt            <= '0;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= bus.req_we;
                            bus.dmem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.dmem_be    <= store_be(bus.req_we, bus.req_funct3,
                                                       bus.req_addr[1:0]);
                            bus.dmem_wdata <= store_data(bus.req_we, bus.req_funct3,
                                                         bus.req_wdata);
                        end
                    end
                end
                StReq: begin
                    cnt <= cnt + 1'b1;
                    if (bus.dmem_gnt) begin
                        state        <= StWait;
                        bus.dmem_req <= 1'b0;
                    end else if (cnt >= CntLast) begin
                        state         <= StResp;
                        bus.dmem_req  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rf_we <= 1'b0;
                        bus.rsp_rd    <= op_rd;
                        bus.rsp_rdata <= 32'h0;
                        bus.rsp_err   <= ErrTimeout;
                    end
                end
                StWait: begin
                    // The counter never passes TIMEOUT_CYC: the cycle after a grant at
                    // the last REQ count is the final chance for rvalid.
                    cnt <= cnt + 1'b1;
                    if (bus.dmem_rvalid) begin
                        state         <= StResp;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rf_we <= !op_we;
                        bus.rsp_rd    <= op_rd;
                        bus.rsp_rdata <= op_we ? 32'h0 : load_ext(op_f3, op_off,
                                                                  bus.dmem_rdata);
                        bus.rsp_err   <= ErrNone;
                    end else if (cnt >= CntLast) begin
                        state         <= StResp;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rf_we <= 1'b0;
                        bus.rsp_rd    <= op_rd;
                        bus.rsp_rdata <= 32'h0;
                        bus.rsp_err   <= ErrTimeout;
                    end
                end
                StResp: begin
                    state         <= StIdle;
                    bus.req_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rf_we <= 1'b0;
                    bus.rsp_rd    <= 5'd0;
                    bus.rsp_rdata <= 32'h0;
                    bus.rsp_err   <= ErrNone;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: expected responses are queued when an op is issued and
// compared by a monitor when rsp_valid pulses; bus timing is checked inline.
module tb_lsu;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rf_we;
        logic [1:0]  err;
        logic [4:0]  rd;
    } rsp_t;

    rsp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] err_model(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                        (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2'b11;
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) return 2'b01;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> (8 * int'(addr[1:0])));
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] be_model(input logic we, input logic [2:0] f3,
                                            input logic [31:0] addr);
        if (!we || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) begin
            case (addr[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        return addr[1] ? 4'b1100 : 4'b0011;
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (f3 == 3'd1) return {d[15:0], d[15:0]};
        return d;
    endfunction

    // Scoreboard monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_rdata", bus.rsp_rdata, e.rdata);
                check_eq("rsp_rf_we", 32'(bus.rsp_rf_we), 32'(e.rf_we));
                check_eq("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check_eq("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        @(negedge clk);
        check_eq("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Full op with bus responder: gnt after gnt_dly REQ cycles, rvalid rv_dly cycles later.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int gnt_dly,
                          input int rv_dly, input logic [31:0] rdata);
        rsp_t e;
        int   drops;
        e.err   = err_model(we, f3, addr);
        e.rd    = rd;
        e.rf_we = (e.err == 2'b00) && !we;
        e.rdata = (e.err == 2'b00 && !we) ? ext_model(f3, addr, rdata) : 32'h0;
        exp_q.push_back(e);
        issue(we, f3, addr, wdata, rd);
        if (e.err != 2'b00) begin
            check_eq("err_rsp_lat", 32'(bus.rsp_valid), 32'd1);
            check_eq("err_no_req", 32'(bus.dmem_req), 32'd0);
        end else begin
            check_eq("dmem_req", 32'(bus.dmem_req), 32'd1);
            check_eq("dmem_we", 32'(bus.dmem_we), 32'(we));
            check_eq("dmem_addr", bus.dmem_addr, {addr[31:2], 2'b00});
            check_eq("dmem_be", 32'(bus.dmem_be), 32'(be_model(we, f3, addr)));
            if (we) check_eq("dmem_wdata", bus.dmem_wdata, wd_model(f3, wdata));
            drops = 0;
            for (int i = 0; i < gnt_dly; i++) begin
                @(posedge clk);
                #1;
                if (!bus.dmem_req) drops++;
            end
            check_eq("req_hold", 32'(drops), 32'd0);
            bus.dmem_gnt = 1'b1;
            @(posedge clk);
            #1;
            bus.dmem_gnt = 1'b0;
            check_eq("req_drop", 32'(bus.dmem_req), 32'd0);
            repeat (rv_dly) begin
                @(posedge clk);
                #1;
            end
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rdata;
            @(posedge clk);
            #1;
            bus.dmem_rvalid = 1'b0;
            bus.dmem_rdata  = $urandom;
            check_eq("rsp_lat", 32'(bus.rsp_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        check_eq("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        check_eq("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int   n;
        rsp_t e;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        rsp_t e;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_we      = 1'b0;
        bus.req_funct3  = 3'd0;
        bus.req_addr    = 32'h0;
        bus.req_wdata   = 32'h0;
        bus.req_rd      = 5'd0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        #12;
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_be", 32'(bus.dmem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads
        run_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd1, 0, 0, 32'hDEADBEEF);
        run_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd2, 0, 0, 32'h80FF0000);
        run_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd3, 0, 0, 32'h80FF0000);
        run_op(1'b0, 3'd5, 32'h102, 32'h0, 5'd4, 0, 0, 32'h80FF0000);
        run_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 1, 2, 32'h80FF0000);
        run_op(1'b0, 3'd0, 32'h101, 32'h0, 5'd6, 3, 1, 32'h1234F600);
        // Stores
        run_op(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 5'd7, 0, 0, 32'h0);
        run_op(1'b1, 3'd0, 32'h101, 32'h00000055, 5'd8, 2, 0, 32'h0);
        run_op(1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 5'd9, 0, 3, 32'h0);
        // Error paths
        run_op(1'b0, 3'd2, 32'h101, 32'h0, 5'd10, 0, 0, 32'h0);
        run_op(1'b0, 3'd7, 32'h100, 32'h0, 5'd11, 0, 0, 32'h0);
        run_op(1'b1, 3'd4, 32'h101, 32'h0, 5'd12, 0, 0, 32'h0);
        run_op(1'b1, 3'd1, 32'h103, 32'h0, 5'd13, 0, 0, 32'h0);
        // Grant on the last REQ count still completes normally
        run_op(1'b0, 3'd2, 32'h180, 32'h0, 5'd14, 15, 0, 32'h0BADF00D);

        // rvalid while idle must be ignored
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;

        // Timeout in REQ: gnt never comes
        e = '{rdata: 32'h0, rf_we: 1'b0, err: 2'b10, rd: 5'd15};
        exp_q.push_back(e);
        issue(1'b0, 3'd2, 32'h200, 32'h0, 5'd15);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.dmem_req) break;
            n++;
            @(posedge clk);
            #1;
        end
        check_eq("to_req_cycles", 32'(n), 32'd16);
        check_eq("to_req_rsp", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        check_eq("to_req_ready", 32'(bus.req_ready), 32'd1);

        // Timeout in WAIT: granted immediately, rvalid never comes
        e = '{rdata: 32'h0, rf_we: 1'b0, err: 2'b10, rd: 5'd16};
        exp_q.push_back(e);
        issue(1'b0, 3'd2, 32'h204, 32'h0, 5'd16);
        bus.dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_gnt = 1'b0;
        n = 2;
        while (!bus.rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("to_wait_cycles", 32'(n), 32'd17);
        @(posedge clk);
        #1;

        // Reset while in WAIT: no response, immediate idle
        issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd17);
        bus.dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.dmem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_req", 32'(bus.dmem_req), 32'd0);
        check_eq("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        bus.dmem_rvalid = 1'b1;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        rst_n = 1'b1;
        run_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd18, 0, 0, 32'h13579BDF);

        repeat (4) @(posedge clk);
        #1;
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit, directly downstream of the execute-stage ALU. Takes the ALU result as the effective address, plus rs2 store data and funct3. Runs one data-memory transaction at a time over a req/gnt/rvalid bus. Returns aligned, sign/zero-extended load data or an error to writeback as a one-cycle response pulse.

Parameters:
TIMEOUT_CYC, 16, cycles in REQ+WAIT before the access is abandoned with a timeout error (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  execute presents a memory op
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
req_addr  in  32  effective address (ALU output)
req_wdata  in  32  rs2 value
req_rd  in  5  load destination register
dmem_req  out  1  bus request, held until dmem_gnt
dmem_we  out  1  bus write enable
dmem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  bus accepted request
dmem_rvalid  in  1  read data valid / write ack
dmem_rdata  in  32  read data
rsp_valid  out  1  one-cycle completion pulse
rsp_rf_we  out  1  write RF (error-free load only)
rsp_rd  out  5  echoed req_rd
rsp_rdata  out  32  extended load data (0 for stores and errors)
rsp_err  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3
busy  out  1  state != IDLE

Behaviour:
- All outputs registered; async reset -> state IDLE, every output 0 except req_ready=1. Counter 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid&&req_ready (cycle T), capture all req fields.
  - Legal and aligned -> REQ.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) -> RESP, err 01, no bus activity.
  - Illegal funct3 (load 011/110/111; store 1xx or 011) -> RESP, err 11. Illegal takes priority over misaligned.
- REQ: dmem_req=1 with dmem_we/addr/be/wdata stable until dmem_gnt. On gnt -> WAIT and dmem_req drops next cycle.
- WAIT: on dmem_rvalid -> RESP. rvalid is required >=1 cycle after gnt; rvalid outside WAIT is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No backpressure on the response.
- Minimum latency: accept T -> dmem_req T+1 -> gnt T+1 -> rvalid T+2 -> rsp_valid T+3. Error path: rsp_valid T+1.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - At count==TIMEOUT_CYC-1 with no gnt (REQ) or rvalid (WAIT) -> RESP, err 10, dmem_req forced low.
  - Completion in the same cycle as expiry wins (no error).
- Store lanes (off=addr[1:0]):
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=4'hF.
  - Loads drive be=4'hF, we=0.
- Load extract: LB/LBU byte rdata[8*off+:8]; LH/LHU half rdata[16*off[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend.
- rsp_rf_we=1 only for loads with err 00. rsp_rd is echoed for every response.
- Reset mid-operation (any state): immediate return to IDLE, outstanding bus transaction abandoned, no rsp_valid.

Test Plan:
- LW addr 0x100, gnt at T+1, rvalid at T+2 with rdata 0xDEADBEEF -> dmem_addr 0x100, be F; rsp_valid at T+3, rdata 0xDEADBEEF, rf_we 1, err 00.
- LB addr 0x103, rdata 0x80FF0000 -> rsp_rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SH addr 0x102, wdata 0x1234ABCD -> dmem_addr 0x100, be 4'b1100, dmem_wdata 0xABCDABCD, we 1; after ack rsp_rf_we 0, rdata 0.
- LW addr 0x101 -> dmem_req never asserts, rsp_valid at T+1, err 01. funct3 3'b111 load -> err 11 at T+1.
- TIMEOUT_CYC=16, gnt held 0 -> dmem_req high 16 cycles then low; rsp err 10, rf_we 0, req_ready 1 next cycle.
- rst_n low while in WAIT -> all outputs 0 and req_ready 1 asynchronously; after release, a new LW completes normally.
